rvmyth_pll_rst_seq: RTL and testbench

PLL lock monitor and multi-channel reset sequencer between the avsd_pll_1v8 output clock and the RVMyth cores. It runs on the PLL output clock and measures the raw PLL reference against it in clock cycles. It declares lock after a programmable number of consecutive in-tolerance periods, then releases per-channel core resets one at a time in a staggered sequence. On loss of lock it re-asserts every core reset and records a sticky loss flag.

---
 rtl/rvmyth_clk_pkg.sv | 24 ++
 rtl/ref_period_meter.sv | 82 ++++++++
 rtl/rvmyth_pll_rst_seq.sv | 145 ++++++++++++++
 tb/tb_rvmyth_pll_rst_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvmyth_clk_pkg.sv
// Shared types and helpers for the RVMyth PLL lock monitor / reset sequencer.
//   seq_state_t : sequencer states (acquire, staggered release, run)
//   in_tol()    : inclusive tolerance window test on a measured period
package rvmyth_clk_pkg;

  typedef enum logic [1:0] {
    ACQ     = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  // True when mult-tol <= meas <= mult+tol; the lower bound is clamped at
  // zero so a tolerance wider than the multiplier cannot wrap around.
  function automatic logic in_tol(input int unsigned meas,
                                  input int unsigned mult,
                                  input int unsigned tol);
    int unsigned lo;
    int unsigned hi;
    lo = (tol >= mult) ? 0 : mult - tol;
    hi = mult + tol;
    return (meas >= lo) && (meas <= hi);
  endfunction

endpackage

// File: rtl/ref_period_meter.sv
// Measures the REF period in clk cycles and issues a verdict per period.
//   clk             : PLL output clock
//   reset           : asynchronous active-high reset
//   ref_in          : raw REF, asynchronous to clk
//   verdict_valid_c : one-cycle pulse, a verdict is available (combinational)
//   verdict_good_c  : qualifies verdict_valid_c; 1 = period in tolerance
//   meas_count      : last measured REF period (registered)
module ref_period_meter
  import rvmyth_clk_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned MULT  = 8,
  parameter int unsigned TOL   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ref_in,
  output logic             verdict_valid_c,
  output logic             verdict_good_c,
  output logic [CNT_W-1:0] meas_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  (* async_reg = "true" *) logic s1_q;
  (* async_reg = "true" *) logic s2_q;
  logic             s3_q;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             armed_q, armed_d;
  logic             rise_c, sat_c, timeout_c;

  // REF synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= ref_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~s3_q;
  assign sat_c  = (period_cnt_q == CNT_MAX);

  // Period counter, capture and arming; an edge takes priority over timeout
  always_comb begin
    period_cnt_d = sat_c ? period_cnt_q : period_cnt_q + CNT_W'(1);
    meas_d       = meas_q;
    armed_d      = armed_q;
    timeout_c    = 1'b0;
    if (rise_c) begin
      meas_d       = period_cnt_q;
      period_cnt_d = CNT_W'(1);
      armed_d      = 1'b1;
    end else if (armed_q && sat_c) begin
      // Lost REF: report once, then wait for the next edge to re-arm
      timeout_c = 1'b1;
      armed_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt_q <= '0;
      meas_q       <= '0;
      armed_q      <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      meas_q       <= meas_d;
      armed_q      <= armed_d;
    end
  end

  assign verdict_valid_c = (rise_c & armed_q) | timeout_c;
  assign verdict_good_c  = rise_c & armed_q & in_tol(32'(period_cnt_q), MULT, TOL);
  assign meas_count      = meas_q;

endmodule

// File: rtl/rvmyth_pll_rst_seq.sv
// PLL lock monitor and staggered per-core reset sequencer.
//   clk        : PLL output clock (shared with the cores)
//   reset      : asynchronous active-high reset
//   ref_in     : raw REF, asynchronous to clk
//   clr_lost   : synchronous clear of lock_lost
//   core_reset : active-high reset per core, released one at a time
//   locked     : lock declared
//   lock_lost  : sticky, set when lock drops after being declared
//   meas_count : last measured REF period in clk cycles
module rvmyth_pll_rst_seq
  import rvmyth_clk_pkg::*;
#(
  parameter int unsigned NCH      = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MULT     = 8,
  parameter int unsigned TOL      = 1,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned RST_DLY  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ref_in,
  input  logic             clr_lost,
  output logic [NCH-1:0]   core_reset,
  output logic             locked,
  output logic             lock_lost,
  output logic [CNT_W-1:0] meas_count
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned DLY_W  = (RST_DLY > 1) ? $clog2(RST_DLY) : 1;
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

  seq_state_t        state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
  logic [NCH-1:0]    core_reset_q, core_reset_d;
  logic              locked_q, locked_d;
  logic              lock_lost_q, lock_lost_d;

  logic verdict_valid_c, verdict_good_c;
  logic good_c, bad_c, lock_hit_c, dly_wrap_c, last_ch_c;

  ref_period_meter #(
    .CNT_W (CNT_W),
    .MULT  (MULT),
    .TOL   (TOL)
  ) u_meter (
    .clk             (clk),
    .reset           (reset),
    .ref_in          (ref_in),
    .verdict_valid_c (verdict_valid_c),
    .verdict_good_c  (verdict_good_c),
    .meas_count      (meas_count)
  );

  assign good_c     = verdict_valid_c & verdict_good_c;
  assign bad_c      = verdict_valid_c & ~verdict_good_c;
  assign lock_hit_c = good_c && (good_cnt_q == GOOD_W'(LOCK_CNT - 1));
  assign dly_wrap_c = (dly_cnt_q == DLY_W'(RST_DLY - 1));
  assign last_ch_c  = (ch_idx_q == CH_W'(NCH - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACQ;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACQ:     if (lock_hit_c) state_d = STAGGER;
      STAGGER: begin
        if (bad_c)                        state_d = ACQ;
        else if (dly_wrap_c && last_ch_c) state_d = RUN;
      end
      RUN:     if (bad_c) state_d = ACQ;
      default: state_d = ACQ;
    endcase
  end

  // Counters and output next values; a loss overrides any stagger step
  always_comb begin
    good_cnt_d   = good_cnt_q;
    dly_cnt_d    = dly_cnt_q;
    ch_idx_d     = ch_idx_q;
    core_reset_d = core_reset_q;
    locked_d     = locked_q;
    lock_lost_d  = lock_lost_q & ~clr_lost;
    unique case (state_q)
      ACQ: begin
        if (good_c) begin
          good_cnt_d = good_cnt_q + GOOD_W'(1);
          if (lock_hit_c) begin
            locked_d  = 1'b1;
            dly_cnt_d = '0;
            ch_idx_d  = '0;
          end
        end else if (bad_c) begin
          good_cnt_d = '0;
        end
      end
      STAGGER, RUN: begin
        if (bad_c) begin
          core_reset_d = '1;
          locked_d     = 1'b0;
          lock_lost_d  = 1'b1;
          good_cnt_d   = '0;
        end else if (state_q == STAGGER) begin
          dly_cnt_d = dly_wrap_c ? '0 : dly_cnt_q + DLY_W'(1);
          if (dly_wrap_c) begin
            core_reset_d = core_reset_q & ~(NCH'(1) << ch_idx_q);
            ch_idx_d     = ch_idx_q + CH_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_cnt_q   <= '0;
      dly_cnt_q    <= '0;
      ch_idx_q     <= '0;
      core_reset_q <= '1;
      locked_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      good_cnt_q   <= good_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      ch_idx_q     <= ch_idx_d;
      core_reset_q <= core_reset_d;
      locked_q     <= locked_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign core_reset = core_reset_q;
  assign locked     = locked_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_rvmyth_pll_rst_seq.sv
// Directed bench for rvmyth_pll_rst_seq with an edge-level expectation model.
module tb_rvmyth_pll_rst_seq;

  localparam int NCH      = 3;
  localparam int CNT_W    = 8;
  localparam int MULT     = 8;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 4;
  localparam int RST_DLY  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             ref_in;
  logic             clr_lost;
  logic [NCH-1:0]   core_reset;
  logic             locked;
  logic             lock_lost;
  logic [CNT_W-1:0] meas_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rvmyth_pll_rst_seq #(
    .NCH(NCH), .CNT_W(CNT_W), .MULT(MULT), .TOL(TOL),
    .LOCK_CNT(LOCK_CNT), .RST_DLY(RST_DLY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ref_in     (ref_in),
    .clr_lost   (clr_lost),
    .core_reset (core_reset),
    .locked     (locked),
    .lock_lost  (lock_lost),
    .meas_count (meas_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit             chk_meas;
    int             meas;
    logic [NCH-1:0] core;
    bit             locked;
    bit             lost;
  } exp_t;

  exp_t sb[$];

  // Expectation model state
  bit m_has_prev, m_armed, m_locked, m_lost;
  int m_last_rise, m_good, m_lock_cyc;

  task automatic model_reset();
    m_has_prev = 0; m_armed = 0; m_locked = 0; m_lost = 0;
    m_last_rise = 0; m_good = 0; m_lock_cyc = 0;
  endtask

  function automatic logic [NCH-1:0] exp_core(input int c);
    logic [NCH-1:0] r;
    r = '1;
    if (m_locked)
      for (int i = 0; i < NCH; i++)
        if (c - m_lock_cyc >= RST_DLY * (i + 1)) r[i] = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // REF rise captured from cycle a; verdict lands at edge a+3
  task automatic push_rise(input int a, input int clr_mode);
    exp_t e;
    int   gap;
    bit   good;
    e.chk_meas = m_has_prev;
    e.meas     = 0;
    if (m_has_prev) begin
      gap    = a - m_last_rise;
      e.meas = (gap > 255) ? 255 : gap;
    end
    if (clr_mode == 1) m_lost = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      good = (e.meas >= MULT - TOL) && (e.meas <= MULT + TOL);
      if (!m_locked) begin
        if (good) begin
          m_good++;
          if (m_good == LOCK_CNT) begin
            m_locked   = 1'b1;
            m_lock_cyc = a + 3;
          end
        end else begin
          m_good = 0;
        end
      end else if (!good) begin
        m_locked = 1'b0;
        m_good   = 0;
        m_lost   = 1'b1;
      end
    end
    m_has_prev  = 1'b1;
    m_last_rise = a;
    e.core   = exp_core(a + 3);
    e.locked = m_locked;
    e.lost   = m_lost;
    sb.push_back(e);
  endtask

  // One REF period of p clk cycles; rise jittered 2..8 time units after a
  // clk edge. clr_mode 1: pulse clr_lost into the verdict edge; 2: pulse it
  // one cycle after the verdict edge.
  task automatic ref_cycle(input int p, input int clr_mode);
    exp_t e;
    int   a;
    @(posedge clk);
    #(2 + $urandom_range(6)) ref_in = 1'b1;
    a = cyc;
    push_rise(a, clr_mode);
    repeat (2) @(posedge clk);
    #1 clr_lost = (clr_mode == 1);
    @(posedge clk);
    #1 clr_lost = 1'b0;
    e = sb.pop_front();
    if (e.chk_meas) check("meas_count", 32'(meas_count), 32'(e.meas));
    check("core_reset", 32'(core_reset), 32'(e.core));
    check("locked", 32'(locked), 32'(e.locked));
    check("lock_lost", 32'(lock_lost), 32'(e.lost));
    ref_in = 1'b0;
    if (clr_mode == 2) begin
      clr_lost = 1'b1;
      @(posedge clk);
      #1 clr_lost = 1'b0;
      m_lost = 1'b0;
      repeat (p - 5) @(posedge clk);
    end else begin
      repeat (p - 4) @(posedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core"}, 32'(core_reset), 32'(3'b111));
    check({tag, "_locked"}, 32'(locked), 32'(0));
    check({tag, "_lost"}, 32'(lock_lost), 32'(0));
    check({tag, "_meas"}, 32'(meas_count), 32'(0));
  endtask

  initial begin
    int t_out;
    reset = 1'b1; ref_in = 1'b0; clr_lost = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("por");
    #2 reset = 1'b0;

    // Nominal lock: arming edge plus four good periods
    repeat (5) ref_cycle(8, 0);

    // REF stops: cycle-exact staggered release, then timeout loss
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      check("stagger_core", 32'(core_reset), 32'(exp_core(cyc)));
      check("stagger_locked", 32'(locked), 32'(1));
    end
    check("run_meas", 32'(meas_count), 32'(8));
    t_out = m_last_rise + 257;
    while (cyc < t_out) begin
      @(posedge clk); #1;
    end
    check("pre_timeout_locked", 32'(locked), 32'(1));
    check("pre_timeout_core", 32'(core_reset), 32'(3'b000));
    @(posedge clk); #1;
    check("timeout_core", 32'(core_reset), 32'(3'b111));
    check("timeout_locked", 32'(locked), 32'(0));
    check("timeout_lost", 32'(lock_lost), 32'(1));
    m_locked = 1'b0; m_good = 0; m_armed = 1'b0; m_lost = 1'b1;

    // Restart: saturated measurement arms, four good periods relock
    repeat (5) ref_cycle(8, 0);

    // Tolerance boundaries 7 / 6 / 9 / 10
    ref_cycle(12, 0);
    repeat (4) ref_cycle(7, 0);
    repeat (5) ref_cycle(6, 0);
    repeat (4) ref_cycle(9, 0);
    repeat (5) ref_cycle(10, 0);

    // 8,8,8,10,8,8,8,8: good count restarts at the 10
    repeat (3) ref_cycle(8, 0);
    ref_cycle(10, 0);
    repeat (5) ref_cycle(8, 0);

    // Loss mid-stagger, clear alone, then loss with simultaneous clear
    repeat (2) ref_cycle(8, 0);
    ref_cycle(12, 0);
    ref_cycle(8, 0);
    ref_cycle(8, 2);
    repeat (5) ref_cycle(8, 0);
    ref_cycle(12, 0);
    ref_cycle(8, 1);

    // Asynchronous reset mid-stagger, then full reacquisition
    repeat (6) ref_cycle(8, 0);
    #3 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    @(posedge clk);
    #1 check_reset_vals("held_rst");
    reset = 1'b0;
    model_reset();
    repeat (8) ref_cycle(8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
